// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
    typedef enum logic {IDLE, RD_BUSY} state_t;
    localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: data-over-fetch priority with a starvation streak counter
module arb_prio_sel #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic if_gnt_o,
    output logic d_gnt_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] streak_q, streak_d;
    logic          if_win;
    always_comb begin
        if_win   = if_req_i && (!d_req_i || streak_q == SW'(STARVE_LIMIT));
        if_gnt_o = en_i && if_win;
        d_gnt_o  = en_i && d_req_i && !if_win;
        streak_d = (!if_req_i || if_gnt_o) ? '0 :
                   (d_gnt_o && streak_q != SW'(STARVE_LIMIT)) ? streak_q + 1'b1 : streak_q;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) streak_q <= '0;
        else        streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch and data ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [WIDTH-1:0]  if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [WIDTH-1:0]  if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [WIDTH-1:0]  d_addr_i,
    input  logic [WIDTH-1:0]  d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [WIDTH-1:0]  d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);
    localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [WIDTH-1:0] if_rdata_q, d_rdata_q;
    logic             busy, waiting, rd_issue;
    logic             unused_addr_hi;
    assign unused_addr_hi = ^{if_addr_i[WIDTH-1:ADDR_W], d_addr_i[WIDTH-1:ADDR_W]};
    assign busy    = state_q == RD_BUSY;
    assign waiting = busy && lat_q != '0;
    // Gating with rst_i keeps every output low while reset is asserted.
    arb_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (rst_i && !waiting),
        .if_req_i (if_req_i),
        .d_req_i  (d_req_i),
        .if_gnt_o (if_gnt_o),
        .d_gnt_o  (d_gnt_o)
    );
    always_comb begin
        mem_req_o   = if_gnt_o || d_gnt_o;
        mem_we_o    = d_gnt_o && d_we_i;
        mem_be_o    = if_gnt_o ? BE_WORD : d_gnt_o ? d_be_i : 4'b0000;
        mem_addr_o  = if_gnt_o ? if_addr_i[ADDR_W-1:0] : d_gnt_o ? d_addr_i[ADDR_W-1:0] : '0;
        mem_wdata_o = mem_we_o ? d_wdata_i : '0;
        if_rvalid_o = busy && lat_q == '0 && owner_q == OWN_IF;
        d_rvalid_o  = busy && lat_q == '0 && owner_q == OWN_D;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : d_rdata_q;
        stall_if_o  = rst_i && ((if_req_i && !if_gnt_o) || (owner_q == OWN_IF && waiting));
        stall_mem_o = rst_i && ((d_req_i && !d_gnt_o) || (owner_q == OWN_D && waiting));
        rd_issue    = mem_req_o && !mem_we_o;
        state_d     = (rd_issue || waiting) ? RD_BUSY : IDLE;
        lat_d       = rd_issue ? LW'(MEM_LATENCY - 1) : waiting ? lat_q - 1'b1 : '0;
        owner_d     = rd_issue ? (if_gnt_o ? OWN_IF : OWN_D) : waiting ? owner_q : OWN_NONE;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            if (if_rvalid_o) if_rdata_q <= mem_rdata_i;
            if (d_rvalid_o)  d_rdata_q  <= mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for latency-2 and latency-1 arbiters
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_n;
    logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_req, mem_we, stall_if, stall_mem;
    logic [3:0]  d_be, mem_be;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
    logic        b_mem_req, b_mem_we, b_stall_if, b_stall_mem;
    logic [3:0]  b_mem_be;
    logic [31:0] b_if_addr, b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_mem_addr;
    logic [15:0] s1_a, s2_a, b_s1_a;
    logic [31:0] if_q[$], d_q[$], b_q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be),
        .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stall_if_o(stall_if), .stall_mem_o(stall_mem)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
        .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata), .d_req_i(1'b0), .d_we_i(1'b0), .d_be_i(4'b0000),
        .d_addr_i(32'h0), .d_wdata_i(32'h0), .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .stall_if_o(b_stall_if), .stall_mem_o(b_stall_mem)
    );

    function automatic logic [31:0] f(input logic [15:0] a);
        return a == 16'h0010 ? 32'h00500093 : {a, ~a};
    endfunction

    // Memory model: read data for the address issued MEM_LATENCY cycles earlier.
    always @(posedge clk) begin
        s1_a   <= mem_addr;
        s2_a   <= s1_a;
        b_s1_a <= b_mem_addr;
    end
    assign mem_rdata   = f(s2_a);
    assign b_mem_rdata = f(b_s1_a);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    always @(negedge clk) if (rst_n) begin
        if (if_rvalid)   chk("if_rdata", if_rdata, if_q.size() != 0 ? if_q.pop_front() : 'x);
        if (d_rvalid)    chk("d_rdata", d_rdata, d_q.size() != 0 ? d_q.pop_front() : 'x);
        if (b_if_rvalid) chk("b_if_rdata", b_if_rdata, b_q.size() != 0 ? b_q.pop_front() : 'x);
        if (b_d_rvalid)  chk("b_d_rvalid", 32'(b_d_rvalid), 32'h0);
    end

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
        #12;
        chk("rst_ctl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, stall_if, stall_mem, mem_be}), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        chk("b_rst_ctl", 32'({b_if_gnt, b_d_gnt, b_if_rvalid, b_mem_req, b_stall_if, b_stall_mem, b_mem_be}), 0);
        nxt; rst_n = 1'b1;
        // lone fetch
        nxt; if_req = 1; if_addr = 32'h10; if_q.push_back(32'h00500093);
        smp; chk("t1_gnt", 32'(if_gnt), 1); chk("t1_addr", 32'(mem_addr), 32'h10); chk("t1_be", 32'(mem_be), 4'hf);
        chk("t1_stall0", 32'(stall_if), 0);
        nxt; if_req = 0;
        smp; chk("t1_stall1", 32'(stall_if), 1); chk("t1_gnt1", 32'(if_gnt), 0);
        nxt;
        smp; chk("t1_rvalid", 32'(if_rvalid), 1); chk("t1_rdata", if_rdata, 32'h00500093); chk("t1_stall2", 32'(stall_if), 0);
        nxt;
        smp; chk("t1_hold", if_rdata, 32'h00500093); chk("t1_rv3", 32'(if_rvalid), 0);
        // simultaneous fetch and load
        nxt; if_req = 1; if_addr = 32'h14; d_req = 1; d_we = 0; d_be = 4'hf; d_addr = 32'h40;
        d_q.push_back(f(16'h40)); if_q.push_back(f(16'h14));
        smp; chk("t2_dgnt", 32'(d_gnt), 1); chk("t2_ignt", 32'(if_gnt), 0); chk("t2_stall_if", 32'(stall_if), 1);
        nxt; d_req = 0;
        smp; chk("t2_busy_gnt", 32'({if_gnt, d_gnt}), 0); chk("t2_stall_mem", 32'(stall_mem), 1);
        nxt;
        smp; chk("t2_drv", 32'(d_rvalid), 1); chk("t2_ignt2", 32'(if_gnt), 1); chk("t2_addr", 32'(mem_addr), 32'h14);
        nxt; if_req = 0;
        smp; chk("t2_irv3", 32'(if_rvalid), 0);
        nxt;
        smp; chk("t2_irv4", 32'(if_rvalid), 1);
        // store with a pending fetch
        nxt; d_req = 1; d_we = 1; d_be = 4'b0001; d_addr = 32'h20; d_wdata = 32'hAB;
        if_req = 1; if_addr = 32'h18; if_q.push_back(f(16'h18));
        smp; chk("t3_dgnt", 32'(d_gnt), 1); chk("t3_we", 32'(mem_we), 1); chk("t3_wdata", mem_wdata, 32'hAB);
        chk("t3_be", 32'(mem_be), 4'b0001); chk("t3_ignt", 32'(if_gnt), 0);
        nxt; d_req = 0; d_we = 0;
        smp; chk("t3_ignt1", 32'(if_gnt), 1); chk("t3_we1", 32'(mem_we), 0); chk("t3_wd1", mem_wdata, 0);
        chk("t3_drv", 32'(d_rvalid), 0);
        nxt; if_req = 0;
        smp; nxt; smp; nxt;
        // starvation
        if_req = 1; if_addr = 32'h1C; d_req = 1; d_we = 1; d_be = 4'hf; d_addr = 32'h50; d_wdata = 32'h1;
        if_q.push_back(f(16'h1C));
        for (int i = 0; i < 5; i++) begin
            smp; chk($sformatf("t4_dgnt%0d", i), 32'(d_gnt), 32'(i < 4)); chk($sformatf("t4_ignt%0d", i), 32'(if_gnt), 32'(i == 4));
            if (i < 4) nxt;
        end
        nxt; if_req = 0;
        smp; chk("t4_busy", 32'(d_gnt), 0);
        nxt; if_req = 1; if_addr = 32'h24; if_q.push_back(f(16'h24));
        smp; chk("t4_dprio", 32'(d_gnt), 1); chk("t4_iwait", 32'(if_gnt), 0);
        nxt; d_req = 0; d_we = 0;
        smp; chk("t4_ignt", 32'(if_gnt), 1);
        nxt; if_req = 0;
        smp; nxt; smp; nxt;
        // reset during an outstanding read
        if_req = 1; if_addr = 32'h30;
        smp; chk("t5_gnt", 32'(if_gnt), 1);
        nxt; if_req = 0;
        #2; rst_n = 1'b0; if_req = 1; d_req = 1;
        #1;
        chk("t5_ctl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, stall_if, stall_mem, mem_be}), 0);
        chk("t5_rdata", if_rdata | d_rdata, 0);
        chk("t5_addr", 32'(mem_addr), 0);
        nxt; rst_n = 1'b1; if_req = 0; d_req = 0;
        for (int i = 0; i < 4; i++) begin
            smp; chk($sformatf("t5_quiet%0d", i), 32'({if_rvalid, d_rvalid, stall_if, stall_mem}), 0);
            nxt;
        end
        if_req = 1; if_addr = 32'h34; if_q.push_back(f(16'h34));
        smp; chk("t5_idle_gnt", 32'(if_gnt), 1);
        nxt; if_req = 0;
        smp; nxt; smp; nxt;
        // latency-1 streaming fetches
        b_if_req = 1; b_if_addr = 32'h0; b_q.push_back(f(16'h0));
        smp; chk("t6_gnt0", 32'(b_if_gnt), 1);
        nxt; b_if_addr = 32'h4; b_q.push_back(f(16'h4));
        smp; chk("t6_gnt1", 32'(b_if_gnt), 1); chk("t6_rv1", 32'(b_if_rvalid), 1);
        nxt; b_if_addr = 32'h8; b_q.push_back(f(16'h8));
        smp; chk("t6_gnt2", 32'(b_if_gnt), 1); chk("t6_rv2", 32'(b_if_rvalid), 1);
        nxt; b_if_req = 0;
        smp; chk("t6_rv3", 32'(b_if_rvalid), 1); chk("t6_gnt3", 32'(b_if_gnt), 0);
        nxt; smp;
        chk("if_q_left", if_q.size(), 0);
        chk("d_q_left", d_q.size(), 0);
        chk("b_q_left", b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
